bus_xfer_ctrl: RTL and testbench

- Bus transfer sequencer for the core's shared 16-bit register bus; the initiator side of the register-file bus protocol.
- Per transfer: pulses LDBUS to one source register, captures that register's BOUT, then pulses WR to one or more destination registers with the captured word on BIN.
- One transfer in flight; a simple REQ/BUSY/DONE handshake towards the control unit.

---
 rtl/bus_xfer_ctrl.sv | 141 ++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: LDBUS one source, capture its word, WR it to the masked destinations.
// Optional transfer counter on XFER_CNT when BUSCTL_XFER_CNT_EN is defined.
module bus_xfer_ctrl #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8,
  parameter int NDST  = 8,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  REQ,
  input  logic [SELW-1:0]       SRC_SEL,
  input  logic [NDST-1:0]       DST_MASK,
  input  logic [NSRC*WIDTH-1:0] SRC_DATA,
  output logic [NSRC-1:0]       LDBUS,
  output logic [NDST-1:0]       WR,
  output logic [WIDTH-1:0]      BUS_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [15:0]           XFER_CNT
);

  typedef enum logic [1:0] {IDLE, LOAD, CAPT, WRITE} state_e;

  localparam logic [SELW:0] NSRC_L = (SELW+1)'(NSRC);

  state_e            state_q, state_d;
  logic [SELW-1:0]   src_q, src_d;
  logic [NDST-1:0]   dst_q, dst_d;
  logic              src_ok_q, src_ok_d;
  logic              bad_q, bad_d;
  logic [NSRC-1:0]   ldbus_q, ldbus_d;
  logic [NDST-1:0]   wr_q, wr_d;
  logic [WIDTH-1:0]  bus_out_q, bus_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              sel_ok;

  assign sel_ok = ({1'b0, SRC_SEL} < NSRC_L);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    src_ok_d  = src_ok_q;
    bad_d     = bad_q;
    ldbus_d   = '0;
    wr_d      = '0;
    bus_out_d = bus_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          src_d    = SRC_SEL;
          dst_d    = DST_MASK;
          src_ok_d = sel_ok;
          bad_d    = !sel_ok || (DST_MASK == '0);
          if (sel_ok) ldbus_d = NSRC'(1) << SRC_SEL;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = CAPT;
      CAPT: begin
        // An out-of-range source leaves BUS_OUT and every destination untouched.
        if (src_ok_q) begin
          bus_out_d = SRC_DATA[int'(src_q)*WIDTH +: WIDTH];
          wr_d      = dst_q;
        end
        state_d = WRITE;
      end
      WRITE: begin
        done_d  = 1'b1;
        err_d   = bad_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: the output/data registers are reset too, since reset must clear every output at once.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      src_ok_q  <= 1'b0;
      bad_q     <= 1'b0;
      ldbus_q   <= '0;
      wr_q      <= '0;
      bus_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_ok_q  <= src_ok_d;
      bad_q     <= bad_d;
      ldbus_q   <= ldbus_d;
      wr_q      <= wr_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign LDBUS   = ldbus_q;
  assign WR      = wr_q;
  assign BUS_OUT = bus_out_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

`ifdef BUSCTL_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts on the same edge that raises DONE, only for error-free transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WRITE && !bad_q) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign XFER_CNT = cnt_q;
`else
  assign XFER_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed and random transfers against a timeline model.
// Built with NSRC=6 so out-of-range source selects can be exercised.
module tb_bus_xfer_ctrl;

  localparam int WIDTH = 16;
  localparam int NSRC  = 6;
  localparam int NDST  = 8;
  localparam int SELW  = 3;

  logic                  clk = 1'b0;
  logic                  RST_N;
  logic                  REQ;
  logic [SELW-1:0]       SRC_SEL;
  logic [NDST-1:0]       DST_MASK;
  logic [NSRC*WIDTH-1:0] SRC_DATA;
  logic [NSRC-1:0]       LDBUS;
  logic [NDST-1:0]       WR;
  logic [WIDTH-1:0]      BUS_OUT;
  logic                  BUSY, DONE, ERR;
  logic [15:0]           XFER_CNT;

  int total = 0;
  int bad   = 0;

  // Reference state: last word the bus should hold and the expected transfer count.
  logic [WIDTH-1:0] exp_bus;
  bit               bus_known;
  logic [15:0]      exp_cnt;

  bus_xfer_ctrl #(.WIDTH(WIDTH), .NSRC(NSRC), .NDST(NDST), .SELW(SELW)) dut (
    .clk(clk), .RST_N(RST_N), .REQ(REQ), .SRC_SEL(SRC_SEL), .DST_MASK(DST_MASK),
    .SRC_DATA(SRC_DATA), .LDBUS(LDBUS), .WR(WR), .BUS_OUT(BUS_OUT), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .XFER_CNT(XFER_CNT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NSRC; i++) SRC_DATA[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(BUSY),  32'd0);
    check({tag, "_ldbus"}, 32'(LDBUS), 32'd0);
    check({tag, "_wr"},    32'(WR),    32'd0);
    check({tag, "_done"},  32'(DONE),  32'd0);
    check({tag, "_err"},   32'(ERR),   32'd0);
    check({tag, "_cnt"},   32'(XFER_CNT), 32'(exp_cnt));
  endtask

  // One complete transfer, entered at a negedge with the DUT able to accept a request
  // and left at the negedge after the DONE edge.
  task automatic do_xfer(input string tag, input int src, input logic [NDST-1:0] dst, input bit hold);
    bit               valid;
    logic [NSRC-1:0]  e_ld;
    logic [NDST-1:0]  e_wr;
    logic             e_err;
    logic [WIDTH-1:0] word;
    valid = (src < NSRC);
    e_ld  = valid ? (NSRC'(1) << src) : '0;
    e_wr  = valid ? dst : '0;
    e_err = !valid || (dst == '0);
    word  = valid ? SRC_DATA[src*WIDTH +: WIDTH] : '0;

    SRC_SEL  = SELW'(src);
    DST_MASK = dst;
    REQ      = 1'b1;
    @(negedge clk);
    check({tag, "_e0_ldbus"}, 32'(LDBUS), 32'(e_ld));
    check({tag, "_e0_busy"},  32'(BUSY),  32'd1);
    check({tag, "_e0_wr"},    32'(WR),    32'd0);
    check({tag, "_e0_done"},  32'(DONE),  32'd0);
    check({tag, "_e0_cnt"},   32'(XFER_CNT), 32'(exp_cnt));
    if (bus_known) check({tag, "_e0_bus"}, 32'(BUS_OUT), 32'(exp_bus));
    REQ = hold;
    SRC_SEL  = SELW'($urandom);
    DST_MASK = NDST'($urandom);
    @(negedge clk);
    check({tag, "_e1_ldbus"}, 32'(LDBUS), 32'd0);
    check({tag, "_e1_busy"},  32'(BUSY),  32'd1);
    check({tag, "_e1_wr"},    32'(WR),    32'd0);
    SRC_SEL  = SELW'($urandom);
    DST_MASK = NDST'($urandom);
    @(negedge clk);
    if (valid) begin
      exp_bus   = word;
      bus_known = 1'b1;
    end else begin
      bus_known = 1'b0;
    end
    check({tag, "_e2_wr"},    32'(WR),    32'(e_wr));
    check({tag, "_e2_busy"},  32'(BUSY),  32'd1);
    check({tag, "_e2_ldbus"}, 32'(LDBUS), 32'd0);
    if (bus_known) check({tag, "_e2_bus"}, 32'(BUS_OUT), 32'(exp_bus));
    randomize_data();
    @(negedge clk);
    check({tag, "_e3_done"},  32'(DONE),  32'd1);
    check({tag, "_e3_err"},   32'(ERR),   32'(e_err));
    check({tag, "_e3_busy"},  32'(BUSY),  32'd0);
    check({tag, "_e3_wr"},    32'(WR),    32'd0);
    check({tag, "_e3_ldbus"}, 32'(LDBUS), 32'd0);
    if (bus_known) check({tag, "_e3_bus"}, 32'(BUS_OUT), 32'(exp_bus));
`ifdef BUSCTL_XFER_CNT_EN
    if (!e_err) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  initial begin
    RST_N     = 1'b1;
    REQ       = 1'b0;
    SRC_SEL   = '0;
    DST_MASK  = '0;
    SRC_DATA  = '0;
    exp_bus   = '0;
    bus_known = 1'b1;
    exp_cnt   = '0;

    // Reset asserted before any clock edge must clear outputs immediately.
    #3 RST_N = 1'b0;
    #1;
    check("rst0_ldbus", 32'(LDBUS), 32'd0);
    check("rst0_wr",    32'(WR),    32'd0);
    check("rst0_bus",   32'(BUS_OUT), 32'd0);
    check("rst0_busy",  32'(BUSY),  32'd0);
    check("rst0_done",  32'(DONE),  32'd0);
    check("rst0_err",   32'(ERR),   32'd0);
    check("rst0_cnt",   32'(XFER_CNT), 32'd0);
    @(negedge clk);
    @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // Single transfer: slot3 -> destination 5.
    randomize_data();
    SRC_DATA[3*WIDTH +: WIDTH] = 16'd32;
    do_xfer("basic", 3, 8'b0010_0000, 1'b0);
    check("basic_bus_val", 32'(BUS_OUT), 32'd32);
    @(negedge clk);
    check_idle("basic_after");

    // Broadcast from slot0 to all destinations.
    SRC_DATA[0*WIDTH +: WIDTH] = 16'd64;
    do_xfer("bcast", 0, 8'hFF, 1'b0);
    @(negedge clk);
    check_idle("bcast_after");

    // REQ held high, alternating sources: one transfer every 4 cycles.
    for (int i = 0; i < 4; i++) begin
      do_xfer("held", (i % 2 == 0) ? 1 : 2, NDST'($urandom_range(1, 255)), 1'b1);
    end
    REQ = 1'b0;
    @(negedge clk);
    check_idle("held_after");

    // Invalid requests: out-of-range source, then empty destination mask.
    do_xfer("bad_src", 7, 8'h0F, 1'b0);
    do_xfer("bad_dst", 2, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("bad_after");

    // Random transfers, REQ randomly held across back-to-back transfers.
    for (int i = 0; i < 16; i++) begin
      int          s;
      logic [7:0]  d;
      s = $urandom_range(0, 7);
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      do_xfer("rand", s, d, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        REQ = 1'b0;
        @(negedge clk);
        check_idle("rand_gap");
      end
    end
    REQ = 1'b0;
    @(negedge clk);
    check_idle("rand_after");

    // Reset asserted while WR is high: strobe drops at once and never returns.
    SRC_SEL  = 3'd5;
    DST_MASK = 8'h81;
    REQ      = 1'b1;
    @(negedge clk);
    REQ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_pre_wr", 32'(WR), 32'h81);
    #2 RST_N = 1'b0;
    #1;
    check("rstw_wr",   32'(WR),   32'd0);
    check("rstw_busy", 32'(BUSY), 32'd0);
    check("rstw_bus",  32'(BUS_OUT), 32'd0);
    check("rstw_cnt",  32'(XFER_CNT), 32'd0);
    exp_bus   = '0;
    bus_known = 1'b1;
    exp_cnt   = '0;
    @(negedge clk);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("rstw_after");
    end

    // Two valid transfers after reset.
    do_xfer("post1", 4, 8'h10, 1'b0);
    do_xfer("post2", 1, 8'h06, 1'b0);
    @(negedge clk);
    check_idle("post_final");
`ifdef BUSCTL_XFER_CNT_EN
    check("cnt_two", 32'(XFER_CNT), 32'd2);
`else
    check("cnt_tied", 32'(XFER_CNT), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
